cosim_write_bridge: RTL and testbench

- Parametrised successor to the single-channel DPI write endpoint.
- Accepts (addr, data) write transactions from NCH independent producer channels using valid/ready handshakes.
- Arbitrates between channels round-robin, buffers the granted writes in a DEPTH-entry FIFO, and drains them to one output port that the co-simulation layer (or synthesizable sink) consumes.
- Returns a per-channel completion pulse once each write has been consumed downstream, replacing the blocking per-write response.

---
 rtl/cosim_write_bridge.sv | 156 +++++++++++++++
 tb/tb_cosim_write_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_write_bridge.sv
// ---------------------------------------------------------------------------
// cosim_write_bridge
//
// Collects (addr, data) write transactions from NCH producer channels,
// arbitrates between them round-robin, buffers the granted writes in a
// DEPTH-entry FIFO and drains them to a single output port.  Each write
// consumed downstream produces a one-cycle completion pulse on the
// originating channel's resp_valid bit.
//
// Ports
//   clk         system clock, all state updates on posedge
//   rst         synchronous active-high reset
//   in_valid    [NCH]      per-channel write request
//   in_ready    [NCH]      per-channel accept (one-hot grant)
//   in_addr     [NCH*AW]   channel i at [i*AW +: AW]
//   in_data     [NCH*DW]   channel i at [i*DW +: DW]
//   out_valid              FIFO head valid
//   out_ready              downstream accept
//   out_addr    [AW]       head address
//   out_data    [DW]       head data
//   out_ch      [CW]       originating channel of the head entry
//   resp_valid  [NCH]      completion pulse, one cycle after the pop
//   fifo_level  [LW]       current occupancy
// ---------------------------------------------------------------------------
module cosim_write_bridge #(
    parameter  int NCH   = 4,
    parameter  int AW    = 32,
    parameter  int DW    = 32,
    parameter  int DEPTH = 8,
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic [NCH*AW-1:0] in_addr,
    input  logic [NCH*DW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW-1:0]     out_addr,
    output logic [DW-1:0]     out_data,
    output logic [CW-1:0]     out_ch,
    output logic [NCH-1:0]    resp_valid,
    output logic [LW-1:0]     fifo_level
);

    localparam int PW = $clog2(DEPTH);

    // Unpacked views of the per-channel buses
    logic [AW-1:0] ch_addr [NCH];
    logic [DW-1:0] ch_data [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            assign ch_addr[gi] = in_addr[gi*AW +: AW];
            assign ch_data[gi] = in_data[gi*DW +: DW];
        end
    endgenerate

    // FIFO storage
    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [CW-1:0] mem_ch   [DEPTH];

    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]  level_q,  level_d;
    logic [CW-1:0]  rr_q,     rr_d;
    logic [NCH-1:0] resp_q,   resp_d;

    logic           full;
    logic           grant_any;
    logic [CW-1:0]  grant_idx;
    logic [NCH-1:0] grant_oh;
    logic           push;
    logic           pop;

    // Full blocks the push even when a pop happens in the same cycle, so
    // in_ready never depends on out_ready.
    assign full = (level_q == LW'(DEPTH));

    // Round-robin arbiter: first pass looks at channels at or above rr,
    // second pass wraps around to the lower channels.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (!rst && !full) begin
            for (int i = 0; i < NCH; i++) begin
                if (!grant_any && in_valid[i] && (CW'(i) >= rr_q)) begin
                    grant_any = 1'b1;
                    grant_idx = CW'(i);
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (!grant_any && in_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = CW'(i);
                end
            end
        end
        grant_oh = grant_any ? (NCH'(1) << grant_idx) : '0;
    end

    assign in_ready  = grant_oh;
    assign push      = grant_any;
    assign out_valid = (level_q != '0);
    assign pop       = out_valid && out_ready;

    // Head is read straight from storage so a write lands on the output
    // one cycle after it is accepted.
    assign out_addr   = mem_addr[rd_ptr_q];
    assign out_data   = mem_data[rd_ptr_q];
    assign out_ch     = mem_ch[rd_ptr_q];
    assign resp_valid = resp_q;
    assign fifo_level = level_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        rr_d     = rr_q;
        if (grant_any) begin
            rr_d = (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + CW'(1);
        end
        resp_d = pop ? (NCH'(1) << out_ch) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            rr_q     <= '0;
            resp_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            rr_q     <= rr_d;
            resp_q   <= resp_d;
        end
    end

    // Storage needs no reset: push is already suppressed while rst is high
    // and stale entries are unreachable once the level is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= ch_addr[grant_idx];
            mem_data[wr_ptr_q] <= ch_data[grant_idx];
            mem_ch[wr_ptr_q]   <= grant_idx;
        end
    end

endmodule

// File: tb/tb_cosim_write_bridge.sv
module tb_cosim_write_bridge;

    localparam int NCH   = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*AW-1:0] in_addr;
    logic [NCH*DW-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_addr;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_ch;
    logic [NCH-1:0]    resp_valid;
    logic [3:0]        fifo_level;

    cosim_write_bridge #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .resp_valid (resp_valid),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard entry
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    ch;
    } entry_t;

    entry_t         sb[$];
    int             m_rr = 0;
    logic [NCH-1:0] m_resp = '0;
    logic [NCH-1:0] last_grant = '0;
    bit             mon_en = 1'b0;

    // Reference arbiter: rotate from rr, first requester wins
    function automatic logic [NCH-1:0] mgrant(input logic [NCH-1:0] v, input int rr,
                                              input bit full, input logic r);
        if (r || full) return '0;
        for (int k = 0; k < NCH; k++) begin
            int i;
            i = (rr + k) % NCH;
            if (v[i]) return NCH'(1) << i;
        end
        return '0;
    endfunction

    // Cycle monitor: compares outputs, then advances the model to the state
    // after the coming posedge.
    always @(negedge clk) begin
        logic [NCH-1:0] eg;
        bit             mpop;
        entry_t         e;
        if (mon_en) begin
            eg = mgrant(in_valid, m_rr, sb.size() == DEPTH, rst);
            chk("in_ready", 64'(in_ready), 64'(eg));
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            chk("fifo_level", 64'(fifo_level), 64'(sb.size()));
            chk("resp_valid", 64'(resp_valid), 64'(m_resp));
            if (sb.size() != 0) begin
                chk("out_addr", 64'(out_addr), 64'(sb[0].addr));
                chk("out_data", 64'(out_data), 64'(sb[0].data));
                chk("out_ch", 64'(out_ch), 64'(sb[0].ch));
            end
            mpop = (sb.size() != 0) && out_ready;
            if (rst) begin
                sb.delete();
                m_rr   = 0;
                m_resp = '0;
            end else begin
                m_resp = mpop ? (NCH'(1) << sb[0].ch) : '0;
                if (mpop) void'(sb.pop_front());
                for (int g = 0; g < NCH; g++) begin
                    if (eg[g]) begin
                        e.addr = in_addr[g*AW +: AW];
                        e.data = in_data[g*DW +: DW];
                        e.ch   = 2'(g);
                        sb.push_back(e);
                        $display("push ch=%0d addr=0x%0h data=0x%0h", g, e.addr, e.data);
                        m_rr = (g + 1) % NCH;
                    end
                end
            end
            last_grant = rst ? '0 : eg;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_addr[i*AW +: AW] = a;
        in_data[i*DW +: DW] = d;
    endtask

    typedef struct {
        logic [NCH-1:0] valid;
        logic [NCH-1:0] exp_ready;
    } vec_t;

    vec_t vecs[10];
    int   cnt;
    int   guard;

    initial begin
        // Round-robin vectors, starting from rr=0 after reset, out_ready=1
        vecs[0] = '{4'b1111, 4'b0001};
        vecs[1] = '{4'b1111, 4'b0010};
        vecs[2] = '{4'b1001, 4'b1000};
        vecs[3] = '{4'b0110, 4'b0010};
        vecs[4] = '{4'b0000, 4'b0000};
        vecs[5] = '{4'b0011, 4'b0001};
        vecs[6] = '{4'b0001, 4'b0001};
        vecs[7] = '{4'b1111, 4'b0010};
        vecs[8] = '{4'b0100, 4'b0100};
        vecs[9] = '{4'b1110, 4'b1000};

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        in_addr   = '0;
        in_data   = '0;

        // Reset: two cycles with all channels requesting
        step();
        mon_en    = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1 chk("reset_in_ready", 64'(in_ready), 64'h0);
        step();
        chk("reset_level", 64'(fifo_level), 64'h0);
        rst = 1'b0;
        #1 chk("post_reset_grant", 64'(in_ready), 64'h1);

        // Table-driven round-robin
        for (int v = 0; v < 10; v++) begin
            in_valid = vecs[v].valid;
            for (int i = 0; i < NCH; i++)
                set_lane(i, 32'hA000_0000 | (i << 8) | v, $urandom);
            #1 chk($sformatf("rr_vec%0d", v), 64'(in_ready), 64'(vecs[v].exp_ready));
            step();
        end
        in_valid = '0;
        repeat (3) step();

        // Single write from ch2
        in_valid = 4'b0100;
        set_lane(2, 32'h10, 32'h41);
        step();
        in_valid = '0;
        chk("single_valid", 64'(out_valid), 64'h1);
        chk("single_addr", 64'(out_addr), 64'h10);
        chk("single_data", 64'(out_data), 64'h41);
        chk("single_ch", 64'(out_ch), 64'h2);
        chk("single_no_resp_yet", 64'(resp_valid), 64'h0);
        step();
        chk("single_resp", 64'(resp_valid), 64'b0100);
        chk("single_drained", 64'(out_valid), 64'h0);
        step();
        chk("single_resp_once", 64'(resp_valid), 64'h0);
        repeat (2) step();

        // Backpressure: ch0 offers 10 writes, only 8 fit
        out_ready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 4'b0001;
            set_lane(0, 32'h100 + cnt, 32'(cnt));
            step();
            if (last_grant[0]) cnt++;
        end
        chk("full_level", 64'(fifo_level), 64'd8);
        chk("full_ready0", 64'(in_ready[0]), 64'h0);

        // Full with concurrent pop: ch1 must wait one cycle
        in_valid  = 4'b0010;
        set_lane(1, 32'h200, 32'hBEEF);
        out_ready = 1'b1;
        #1 chk("full_pop_no_push", 64'(in_ready), 64'h0);
        step();
        chk("full_pop_level7", 64'(fifo_level), 64'd7);
        out_ready = 1'b0;
        #1 chk("full_pop_push_next", 64'(in_ready), 64'b0010);
        step();
        in_valid = '0;
        chk("full_pop_level8", 64'(fifo_level), 64'd8);

        // Drain while ch0 delivers its remaining writes
        out_ready = 1'b1;
        guard = 0;
        while ((cnt < 10 || sb.size() != 0) && guard < 40) begin
            in_valid = (cnt < 10) ? 4'b0001 : 4'b0000;
            set_lane(0, 32'h100 + cnt, 32'(cnt));
            step();
            if (last_grant[0]) cnt++;
            guard++;
        end
        in_valid = '0;
        step();
        chk("drain_empty", 64'(fifo_level), 64'h0);
        chk("drain_bounded", 64'(guard < 40), 64'h1);
        repeat (2) step();

        // Reset with 5 entries buffered
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'b1000;
            set_lane(3, 32'h300 + k, 32'h3000 + k);
            step();
        end
        in_valid = '0;
        chk("midrst_level5", 64'(fifo_level), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_level", 64'(fifo_level), 64'h0);
        chk("midrst_valid", 64'(out_valid), 64'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("midrst_no_resp%0d", k), 64'(resp_valid), 64'h0);
            step();
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
